// File: rtl/dev_mem_ctrl_pkg.sv
// Shared constants for the device memory controller: region map, UART
// register addresses and controller state encodings.
package dev_mem_ctrl_pkg;

    localparam logic [31:0] SRAM_BASE      = 32'h0000_0000;
    localparam logic [31:0] SRAM_MASK      = 32'hFFC0_0000;
    localparam logic [31:0] ROM_BASE       = 32'h1FC0_0000;
    localparam logic [31:0] ROM_MASK       = 32'hFFFF_F000;
    localparam logic [31:0] UART_DAT_ADDR  = 32'h1FD0_03F8;
    localparam logic [31:0] UART_STAT_ADDR = 32'h1FD0_03FC;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_SRAM_RD      = 3'd1;
    localparam logic [2:0] ST_SRAM_WR      = 3'd2;
    localparam logic [2:0] ST_SRAM_WR_HOLD = 3'd3;
    localparam logic [2:0] ST_ROM_RD       = 3'd4;
    localparam logic [2:0] ST_UART_TX_WAIT = 3'd5;

    // Word-address region match; byte-offset bits never take part.
    function automatic logic in_region(input logic [29:0] word_addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
        return (word_addr & mask[31:2]) == base[31:2];
    endfunction

endpackage

// File: rtl/dev_addr_decode.sv
// Combinational region decoder for the device port; exactly one output is
// high for any word address.
module dev_addr_decode
    import dev_mem_ctrl_pkg::*;
(
    input  logic [29:0] word_addr,
    output logic        is_sram,
    output logic        is_rom,
    output logic        is_uart_dat,
    output logic        is_uart_stat,
    output logic        is_unmapped
);

    assign is_sram      = in_region(word_addr, SRAM_BASE, SRAM_MASK);
    assign is_rom       = in_region(word_addr, ROM_BASE, ROM_MASK);
    assign is_uart_dat  = (word_addr == UART_DAT_ADDR[31:2]);
    assign is_uart_stat = (word_addr == UART_STAT_ADDR[31:2]);
    assign is_unmapped  = !(is_sram || is_rom || is_uart_dat || is_uart_stat);

endmodule

// File: rtl/dev_mem_ctrl.sv
// Physical-memory back end behind the MMU device port: decodes each access
// and sequences async SRAM, sync boot ROM and UART registers behind mem_busy.
module dev_mem_ctrl
    import dev_mem_ctrl_pkg::*;
#(
    parameter int SRAM_WAIT = 2,
    parameter int ROM_AW    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_data_w,
    input  logic              mem_is_write,
    output logic [31:0]       mem_data_r,
    output logic              mem_busy,
    output logic [19:0]       sram_addr,
    inout  wire  [31:0]       sram_data,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [7:0]        uart_tx_data,
    output logic              uart_tx_start,
    input  logic              uart_tx_busy,
    input  logic [7:0]        uart_rx_data,
    input  logic              uart_rx_valid,
    output logic              uart_rx_ack
);

    localparam int CW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [29:0]   tag_addr;
    logic          tag_valid;
    logic          wr_armed;
    logic [31:0]   sram_wdata;
    logic [29:0]   word_addr;
    logic          is_sram, is_rom, is_uart_dat, is_uart_stat, is_unmapped;
    logic          rd_req, wr_req, start;
    logic          unused;

    assign word_addr = mem_addr[31:2];
    assign unused    = ^{mem_addr[1:0], is_unmapped};

    dev_addr_decode u_decode (
        .word_addr    (word_addr),
        .is_sram      (is_sram),
        .is_rom       (is_rom),
        .is_uart_dat  (is_uart_dat),
        .is_uart_stat (is_uart_stat),
        .is_unmapped  (is_unmapped)
    );

    // A held read address is served once from the tag; a held write strobe
    // is served once via wr_armed.
    assign rd_req   = !mem_is_write && (!tag_valid || word_addr != tag_addr);
    assign wr_req   = mem_is_write && wr_armed;
    assign start    = (state == ST_IDLE) && (rd_req || wr_req);
    assign mem_busy = (state != ST_IDLE) || start;

    assign sram_data = (state == ST_SRAM_WR || state == ST_SRAM_WR_HOLD) ? sram_wdata : 32'bz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            tag_addr      <= '0;
            tag_valid     <= 1'b0;
            wr_armed      <= 1'b1;
            mem_data_r    <= '0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            rom_addr      <= '0;
            uart_tx_data  <= '0;
            uart_tx_start <= 1'b0;
            uart_rx_ack   <= 1'b0;
        end else begin
            uart_tx_start <= 1'b0;
            uart_rx_ack   <= 1'b0;
            if (!mem_is_write)
                wr_armed <= 1'b1;
            else if (start)
                wr_armed <= 1'b0;

            case (state)
                ST_IDLE: if (start) begin
                    tag_valid <= 1'b0;
                    if (mem_is_write) begin
                        if (is_sram) begin
                            sram_addr  <= mem_addr[21:2];
                            sram_wdata <= mem_data_w;
                            sram_ce_n  <= 1'b0;
                            sram_we_n  <= 1'b0;
                            cnt        <= CW'(SRAM_WAIT - 1);
                            state      <= ST_SRAM_WR;
                        end else if (is_uart_dat) begin
                            uart_tx_data <= mem_data_w[7:0];
                            if (uart_tx_busy)
                                state <= ST_UART_TX_WAIT;
                            else
                                uart_tx_start <= 1'b1;
                        end
                    end else begin
                        tag_addr <= word_addr;
                        if (is_sram) begin
                            sram_addr <= mem_addr[21:2];
                            sram_ce_n <= 1'b0;
                            sram_oe_n <= 1'b0;
                            cnt       <= CW'(SRAM_WAIT - 1);
                            state     <= ST_SRAM_RD;
                        end else if (is_rom) begin
                            rom_addr <= mem_addr[ROM_AW+1:2];
                            state    <= ST_ROM_RD;
                        end else if (is_uart_stat) begin
                            mem_data_r <= {30'b0, uart_rx_valid, ~uart_tx_busy};
                        end else if (is_uart_dat) begin
                            mem_data_r  <= {24'b0, uart_rx_data};
                            uart_rx_ack <= uart_rx_valid;
                        end else begin
                            mem_data_r <= '0;
                            tag_valid  <= 1'b1;
                        end
                    end
                end
                ST_SRAM_RD: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        mem_data_r <= sram_data;
                        sram_oe_n  <= 1'b1;
                        sram_ce_n  <= 1'b1;
                        tag_valid  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                ST_SRAM_WR: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        sram_we_n <= 1'b1;
                        state     <= ST_SRAM_WR_HOLD;
                    end
                end
                // Data and chip enable outlast we_n by a cycle for hold time.
                ST_SRAM_WR_HOLD: begin
                    sram_ce_n <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_ROM_RD: begin
                    mem_data_r <= rom_data;
                    tag_valid  <= 1'b1;
                    state      <= ST_IDLE;
                end
                ST_UART_TX_WAIT: if (!uart_tx_busy) begin
                    uart_tx_start <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dev_mem_ctrl.sv
// Scoreboard bench for dev_mem_ctrl with behavioural SRAM, ROM and UART models.
module tb_dev_mem_ctrl;

    localparam logic [31:0] UART_DAT  = 32'h1FD0_03F8;
    localparam logic [31:0] UART_STAT = 32'h1FD0_03FC;
    localparam logic [31:0] UNMAPPED  = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr, mem_data_w, mem_data_r;
    logic        mem_is_write, mem_busy;
    logic [19:0] sram_addr;
    wire  [31:0] sram_data;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic [7:0]  uart_tx_data, uart_rx_data;
    logic        uart_tx_start, uart_tx_busy, uart_rx_valid, uart_rx_ack;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    int oe_low_cyc = 0, we_low_cyc = 0, we_pulses = 0, tx_pulses = 0, ack_pulses = 0;
    logic [7:0] tx_last = 8'h0;

    dev_mem_ctrl #(.SRAM_WAIT(2), .ROM_AW(10)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_data_w(mem_data_w), .mem_is_write(mem_is_write),
        .mem_data_r(mem_data_r), .mem_busy(mem_busy),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start), .uart_tx_busy(uart_tx_busy),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ack(uart_rx_ack)
    );

    always #5 clk = ~clk;

    // Async SRAM: reads while ce_n/oe_n low, latches on the rising edge of we_n.
    logic [31:0] sram_mem [0:(1<<20)-1];
    assign sram_data = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 32'bz;
    always @(posedge sram_we_n) if (!sram_ce_n) sram_mem[sram_addr] = sram_data;

    assign rom_data = {22'h0, rom_addr} ^ 32'hA5A5_0000;

    // Pre-edge samples: a strobe low at N posedges was held low for N cycles.
    always @(posedge clk) begin
        if (!sram_oe_n) oe_low_cyc++;
        if (!sram_we_n) we_low_cyc++;
        if (uart_tx_start) begin tx_pulses++; tx_last = uart_tx_data; end
        if (uart_rx_ack) ack_pulses++;
    end
    always @(negedge sram_we_n) we_pulses++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] pop_exp();
        if (exp_q.size() == 0) return 32'hxxxx_xxxx;
        return exp_q.pop_front();
    endfunction

    task automatic wait_idle(output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!mem_busy) break;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_addr = UNMAPPED; mem_is_write = 1'b0; mem_data_w = '0;
        uart_tx_busy = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 111", {sram_ce_n, sram_oe_n, sram_we_n});
        end
        n_checks++;
        if (mem_data_r !== 32'h0) begin n_fail++; $display("FAIL reset_data_r: got %h expected 0", mem_data_r); end
        n_checks++;
        if ({uart_tx_start, uart_rx_ack, uart_tx_data, sram_addr, rom_addr} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: tx_start=%b rx_ack=%b tx_data=%h sram_addr=%h rom_addr=%h expected all 0",
                               uart_tx_start, uart_rx_ack, uart_tx_data, sram_addr, rom_addr);
        end
        rst = 1'b1;
        exp_q.push_back(32'h0);
        @(negedge clk);
        n_checks++;
        if (mem_busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", mem_busy); end
        n_checks++;
        if (mem_data_r !== pop_exp()) begin n_fail++; $display("FAIL reset_unmapped_rd: got %h expected 0", mem_data_r); end
    endtask

    task automatic test_sram_read();
        int cyc = 0; int oe0; bit addr_bad = 0; logic [31:0] e;
        oe0 = oe_low_cyc;
        mem_addr = 32'h0000_0010;
        exp_q.push_back(32'hDEAD_BEEF);
        #1;
        n_checks++;
        if (mem_busy !== 1'b1) begin n_fail++; $display("FAIL sram_rd_busy_early: got %b expected 1", mem_busy); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!mem_busy) break;
            cyc++;
            if (sram_addr !== 20'h00004) addr_bad = 1;
        end
        n_checks++;
        if (cyc != 2) begin n_fail++; $display("FAIL sram_rd_latency: got %0d expected 2", cyc); end
        n_checks++;
        if (addr_bad) begin n_fail++; $display("FAIL sram_rd_addr: got %h expected 00004", sram_addr); end
        n_checks++;
        if (oe_low_cyc - oe0 != 2) begin n_fail++; $display("FAIL sram_rd_oe_width: got %0d expected 2", oe_low_cyc - oe0); end
        e = pop_exp();
        n_checks++;
        if (mem_data_r !== e) begin n_fail++; $display("FAIL sram_rd_data: got %h expected %h", mem_data_r, e); end
    endtask

    task automatic test_tag_hit();
        int cyc; int oe0; bit busy_seen = 0; logic [31:0] e;
        oe0 = oe_low_cyc;
        repeat (3) begin @(negedge clk); if (mem_busy) busy_seen = 1; end
        n_checks++;
        if (busy_seen || oe_low_cyc != oe0) begin
            n_fail++; $display("FAIL tag_hit_idle: busy_seen=%b oe_cycles=%0d expected 0/0", busy_seen, oe_low_cyc - oe0);
        end
        mem_addr = 32'h0000_0014;
        exp_q.push_back(32'hCAFE_F00D);
        wait_idle(cyc);
        n_checks++;
        if (cyc != 2) begin n_fail++; $display("FAIL tag_miss_latency: got %0d expected 2", cyc); end
        e = pop_exp();
        n_checks++;
        if (mem_data_r !== e) begin n_fail++; $display("FAIL tag_miss_data: got %h expected %h", mem_data_r, e); end
    endtask

    task automatic test_sram_write();
        int cyc; int we0, wp0; bit not_busy = 0; logic [31:0] e;
        we0 = we_low_cyc; wp0 = we_pulses;
        mem_addr = 32'h0000_0010; mem_data_w = 32'h1234_5678; mem_is_write = 1'b1;
        repeat (3) begin @(negedge clk); if (!mem_busy) not_busy = 1; end
        n_checks++;
        if (not_busy) begin n_fail++; $display("FAIL sram_wr_busy: busy dropped early, expected 3 busy cycles"); end
        n_checks++;
        if ({sram_we_n, sram_ce_n} !== 2'b10) begin
            n_fail++; $display("FAIL sram_wr_hold: we_n,ce_n got %b expected 10", {sram_we_n, sram_ce_n});
        end
        @(negedge clk);
        n_checks++;
        if ({mem_busy, sram_ce_n} !== 2'b01) begin
            n_fail++; $display("FAIL sram_wr_done: busy,ce_n got %b expected 01", {mem_busy, sram_ce_n});
        end
        @(negedge clk);
        n_checks++;
        if (mem_busy !== 1'b0 || we_pulses - wp0 != 1 || we_low_cyc - we0 != 2) begin
            n_fail++; $display("FAIL sram_wr_once: busy=%b pulses=%0d we_low=%0d expected 0/1/2",
                               mem_busy, we_pulses - wp0, we_low_cyc - we0);
        end
        mem_is_write = 1'b0;
        exp_q.push_back(32'h1234_5678);
        wait_idle(cyc);
        n_checks++;
        if (cyc != 2) begin n_fail++; $display("FAIL raw_refetch_latency: got %0d expected 2", cyc); end
        e = pop_exp();
        n_checks++;
        if (mem_data_r !== e) begin n_fail++; $display("FAIL raw_refetch_data: got %h expected %h", mem_data_r, e); end
    endtask

    task automatic test_uart_tx();
        int tp0; bit not_busy = 0;
        tp0 = tx_pulses;
        uart_tx_busy = 1'b1;
        mem_addr = UART_DAT; mem_data_w = 32'hFFFF_FF41; mem_is_write = 1'b1;
        repeat (5) begin @(negedge clk); if (!mem_busy) not_busy = 1; end
        n_checks++;
        if (not_busy || tx_pulses != tp0) begin
            n_fail++; $display("FAIL uart_tx_wait: busy_dropped=%b pulses=%0d expected 0/0", not_busy, tx_pulses - tp0);
        end
        uart_tx_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_busy, uart_tx_start} !== 2'b01 || uart_tx_data !== 8'h41) begin
            n_fail++; $display("FAIL uart_tx_fire: busy,start got %b data %h expected 01 data 41",
                               {mem_busy, uart_tx_start}, uart_tx_data);
        end
        mem_is_write = 1'b0; mem_addr = UNMAPPED;
        @(negedge clk);
        n_checks++;
        if (tx_pulses - tp0 != 1 || tx_last !== 8'h41) begin
            n_fail++; $display("FAIL uart_tx_pulse: got %0d pulses byte %h expected 1 byte 41", tx_pulses - tp0, tx_last);
        end
    endtask

    task automatic test_uart_regs();
        int a0; logic [31:0] e;
        a0 = ack_pulses;
        mem_addr = UART_STAT; uart_rx_valid = 1'b1; uart_rx_data = 8'h5A; uart_tx_busy = 1'b0;
        exp_q.push_back(32'h3);
        @(negedge clk);
        e = pop_exp();
        n_checks++;
        if (mem_data_r !== e || uart_rx_ack !== 1'b0) begin
            n_fail++; $display("FAIL uart_status: got %h ack %b expected %h ack 0", mem_data_r, uart_rx_ack, e);
        end
        mem_addr = UART_DAT;
        exp_q.push_back(32'h5A);
        @(negedge clk);
        e = pop_exp();
        n_checks++;
        if (mem_data_r !== e || uart_rx_ack !== 1'b1) begin
            n_fail++; $display("FAIL uart_data: got %h ack %b expected %h ack 1", mem_data_r, uart_rx_ack, e);
        end
        mem_addr = UNMAPPED; uart_rx_valid = 1'b0;
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = pop_exp();
        n_checks++;
        if (mem_data_r !== e || mem_busy !== 1'b0) begin
            n_fail++; $display("FAIL unmapped_rd: got %h busy %b expected %h busy 0", mem_data_r, mem_busy, e);
        end
        @(negedge clk);
        n_checks++;
        if (ack_pulses - a0 != 1) begin n_fail++; $display("FAIL uart_rx_ack_count: got %0d expected 1", ack_pulses - a0); end
    endtask

    task automatic test_rom();
        int cyc; logic [31:0] e;
        mem_addr = 32'h1FC0_0100;
        exp_q.push_back(32'hA5A5_0040);
        wait_idle(cyc);
        n_checks++;
        if (cyc != 1) begin n_fail++; $display("FAIL rom_latency: got %0d expected 1", cyc); end
        e = pop_exp();
        n_checks++;
        if (mem_data_r !== e || rom_addr !== 10'h040) begin
            n_fail++; $display("FAIL rom_data: got %h addr %h expected %h addr 040", mem_data_r, rom_addr, e);
        end
    endtask

    task automatic test_reset_mid_write();
        int cyc; logic [31:0] e;
        mem_addr = 32'h0000_0020; mem_data_w = 32'h55AA_55AA; mem_is_write = 1'b1;
        @(negedge clk);
        n_checks++;
        if (sram_we_n !== 1'b0) begin n_fail++; $display("FAIL rst_wr_inflight: we_n got %b expected 0", sram_we_n); end
        #2 rst = 1'b0; mem_is_write = 1'b0; mem_addr = 32'h0000_0010;
        #1;
        n_checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111 || mem_data_r !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_wr: strobes got %b data %h expected 111 data 0",
                               {sram_ce_n, sram_oe_n, sram_we_n}, mem_data_r);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(32'h1234_5678);
        wait_idle(cyc);
        n_checks++;
        if (cyc != 2) begin n_fail++; $display("FAIL rst_refetch_latency: got %0d expected 2", cyc); end
        e = pop_exp();
        n_checks++;
        if (mem_data_r !== e) begin n_fail++; $display("FAIL rst_refetch_data: got %h expected %h", mem_data_r, e); end
    endtask

    initial begin
        sram_mem[20'h00004] = 32'hDEAD_BEEF;
        sram_mem[20'h00005] = 32'hCAFE_F00D;
        test_reset();
        test_sram_read();
        test_tag_hit();
        test_sram_write();
        test_uart_tx();
        test_uart_regs();
        test_rom();
        test_reset_mid_write();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dev_mem_ctrl.md
Name: dev_mem_ctrl

Overview:
- Physical-memory back end that sits directly downstream of the MMU's device port.
- Consumes the translated physical address, write data and write strobe. Produces read data and a busy flag.
- Decodes each access to external async SRAM, internal boot ROM, UART registers, or unmapped space.
- Sequences multi-cycle SRAM timing so the MMU only sees a simple busy/data handshake.

Parameters:
SRAM_WAIT, 2, posedge cycles the SRAM strobe (oe_n or we_n) is held low per access (>=1)
ROM_AW, 10, boot ROM word-address width

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-low
mem_addr  in  32  physical byte address from MMU (bits [1:0] ignored)
mem_data_w  in  32  write data from MMU
mem_is_write  in  1  write strobe from MMU
mem_data_r  out  32  registered read data to MMU
mem_busy  out  1  access pending or in progress
sram_addr  out  20  SRAM word address
sram_data  inout  32  SRAM data bus
sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM controls, active-low
rom_addr  out  ROM_AW  synchronous ROM address
rom_data  in  32  ROM data, valid 1 cycle after rom_addr
uart_tx_data  out  8  byte to transmit
uart_tx_start  out  1  one-cycle transmit pulse
uart_tx_busy  in  1  transmitter busy
uart_rx_data  in  8  received byte
uart_rx_valid  in  1  received byte available
uart_rx_ack  out  1  one-cycle pulse; consumes rx byte

Behaviour:
- Address map (bits [1:0] ignored):
  - SRAM: 0x0000_0000-0x003F_FFFF; sram_addr = mem_addr[21:2].
  - ROM: 0x1FC0_0000-0x1FC0_0FFF; rom_addr = mem_addr[ROM_AW+1:2].
  - UART data: 0x1FD0_03F8.
  - UART status: 0x1FD0_03FC.
  - Everything else is unmapped.
- Request detection:
  - Read request = mem_is_write==0 and (!tag_valid or mem_addr[31:2] != tag_addr).
  - Write request = mem_is_write==1 and wr_armed==1.
  - wr_armed clears when a write is accepted and sets whenever mem_is_write is sampled 0. Each MMU write strobe therefore produces exactly one write.
- start = state==IDLE and (read request or write request).
- mem_busy = (state != IDLE) or start. It is combinational, so the MMU (negedge-sampled) sees busy before the first posedge.
- States: IDLE, SRAM_RD, SRAM_WR, SRAM_WR_HOLD, ROM_RD, UART_TX_WAIT.
- IDLE with start, per target:
  - SRAM read: drive sram_addr, ce_n=0, oe_n=0, cnt=SRAM_WAIT-1, go to SRAM_RD.
  - SRAM write: drive addr and data, ce_n=0, we_n=0, cnt=SRAM_WAIT-1, go to SRAM_WR.
  - ROM read: latch rom_addr, go to ROM_RD.
  - UART status read: mem_data_r={30'b0, uart_rx_valid, ~uart_tx_busy}; stay IDLE.
  - UART data read: mem_data_r={24'b0, uart_rx_data}, pulse uart_rx_ack if uart_rx_valid; stay IDLE.
  - UART data write: if !uart_tx_busy, latch mem_data_w[7:0] and pulse uart_tx_start, stay IDLE; else go to UART_TX_WAIT.
  - Unmapped read: mem_data_r=0. Unmapped write: discarded. Stay IDLE in both cases.
- SRAM_RD: decrement cnt. At cnt==0, capture sram_data into mem_data_r, raise oe_n and ce_n, go to IDLE.
- SRAM_WR: at cnt==0, raise we_n and go to SRAM_WR_HOLD. SRAM_WR_HOLD: ce_n=1, stop driving the bus, go to IDLE.
- sram_data is driven only in SRAM_WR and SRAM_WR_HOLD; it is high-Z otherwise.
- ROM_RD: mem_data_r=rom_data, go to IDLE.
- UART_TX_WAIT: when !uart_tx_busy, pulse uart_tx_start with the latched byte, go to IDLE.
- Tag rules:
  - Every completed read sets tag_addr=mem_addr[31:2] and tag_valid=1.
  - Every accepted write clears tag_valid, so a read-after-write always refetches.
  - UART reads never set tag_valid, so status polling always re-reads.
- Latency from the start posedge to busy low: SRAM read SRAM_WAIT cycles; SRAM write SRAM_WAIT+1; ROM 1; UART and unmapped 0, plus the tx wait.
- Address or strobe changes while busy are ignored until IDLE.
- Reset (async, any state):
  - state=IDLE, mem_data_r=0, tag_valid=0, wr_armed=1.
  - SRAM: ce_n, oe_n, we_n all 1; bus high-Z.
  - uart_tx_start=0, uart_rx_ack=0, uart_tx_data=0, sram_addr=0, rom_addr=0.
  - An access in flight at reset is abandoned with no write completion guaranteed.

Decomposition:
- Shared header constants: region base/mask values, UART register addresses, state encodings.
- One natural sub-module: dev_addr_decode, a combinational region decoder with one-hot outputs is_sram, is_rom, is_uart_dat, is_uart_stat, is_unmapped.

Test Plan:
- SRAM read at 0x0000_0010, model returns 0xDEADBEEF: busy high 2 cycles, then mem_data_r=0xDEADBEEF. sram_addr=0x00004 throughout; oe_n low exactly 2 cycles.
- Same address held afterwards: busy stays 0 and no SRAM strobe occurs. Change to 0x14: a new access starts.
- Write 0x12345678 to 0x0000_0010 with mem_is_write held 3 cycles: exactly one we_n pulse of 2 cycles, then a hold cycle. A following read of 0x10 refetches and returns 0x12345678.
- UART write of 0x41 while uart_tx_busy=1 for 5 cycles: busy stays high, one uart_tx_start pulse with data 0x41 after tx_busy falls.
- Status read with rx_valid=1, tx_busy=0 returns 0x3. Data read returns 0x5A and pulses uart_rx_ack exactly once. Unmapped read of 0x3000_0000 returns 0.
- Reset asserted mid SRAM_WR: we_n, ce_n and oe_n rise immediately, bus goes high-Z, busy=0 after release, tag_valid=0.
